// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the multi-cycle ALU scheduler.
// Opcode encodings mirror the ALU's own opcode table.
package alu_sched_pkg;

    localparam int unsigned NUM_LANES       = 2;
    localparam int unsigned WAIT_BUSY_LIMIT = 4;
    localparam int unsigned ALU_OP_WIDTH    = 7;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 7'h00;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 7'h01;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 7'h05;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL = 7'h20;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StRespond
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer names the lane that wins a tie and
// moves to the other lane whenever a grant is accepted.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = ~grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_mc_scheduler.sv
// Two-lane front end for the ALU multi-cycle path: arbitrates requests,
// launches SRL/SLL/MUL, tracks completion or timeout and returns the result.
module alu_mc_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH    = 64,
    parameter int unsigned OPCODE_ALU_WIDTH = ALU_OP_WIDTH,
    parameter int unsigned DONE_TIMEOUT     = 128
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_LANES-1:0]            req_valid,
    output logic [NUM_LANES-1:0]            req_ready,
    input  logic [2*OPCODE_ALU_WIDTH-1:0]   req_op_code,
    input  logic [2*OPERAND_WIDTH-1:0]      req_operand_1,
    input  logic [2*OPERAND_WIDTH-1:0]      req_operand_2,
    output logic [NUM_LANES-1:0]            rsp_valid,
    input  logic [NUM_LANES-1:0]            rsp_ready,
    output logic [OPERAND_WIDTH-1:0]        rsp_result,
    output logic                            rsp_invalid,
    output logic [OPERAND_WIDTH-1:0]        alu_operand_1,
    output logic [OPERAND_WIDTH-1:0]        alu_operand_2,
    output logic [OPCODE_ALU_WIDTH-1:0]     alu_op_code,
    output logic                            alu_enable_seq,
    input  logic                            alu_idle,
    input  logic [OPERAND_WIDTH-1:0]        alu_result_multi_cycle
);

    localparam int unsigned CNT_WIDTH = $clog2(DONE_TIMEOUT + 1);
    localparam logic [OPCODE_ALU_WIDTH-1:0] OP_SLL = OPCODE_ALU_WIDTH'(ALU_SLL);
    localparam logic [OPCODE_ALU_WIDTH-1:0] OP_SRL = OPCODE_ALU_WIDTH'(ALU_SRL);
    localparam logic [OPCODE_ALU_WIDTH-1:0] OP_MUL = OPCODE_ALU_WIDTH'(ALU_MUL);

    sched_state_e                state_q, state_d;
    logic                        owner_q, owner_d;
    logic [OPCODE_ALU_WIDTH-1:0] op_q, op_d;
    logic [OPERAND_WIDTH-1:0]    opa_q, opa_d;
    logic [OPERAND_WIDTH-1:0]    opb_q, opb_d;
    logic [OPERAND_WIDTH-1:0]    result_q, result_d;
    logic                        invalid_q, invalid_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

    logic [1:0]                  grant;
    logic                        accept;
    logic                        lane_sel;
    logic                        legal;
    logic                        timeout;
    logic                        zero_len;
    logic [OPCODE_ALU_WIDTH-1:0] sel_op;
    logic [OPERAND_WIDTH-1:0]    sel_a, sel_b;

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign req_ready = (state_q == StIdle && alu_idle) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign lane_sel  = grant[1];

    assign sel_op = lane_sel ? req_op_code[2*OPCODE_ALU_WIDTH-1 -: OPCODE_ALU_WIDTH]
                             : req_op_code[OPCODE_ALU_WIDTH-1:0];
    assign sel_a  = lane_sel ? req_operand_1[2*OPERAND_WIDTH-1 -: OPERAND_WIDTH]
                             : req_operand_1[OPERAND_WIDTH-1:0];
    assign sel_b  = lane_sel ? req_operand_2[2*OPERAND_WIDTH-1 -: OPERAND_WIDTH]
                             : req_operand_2[OPERAND_WIDTH-1:0];
    assign legal  = (sel_op == OP_SLL) || (sel_op == OP_SRL) || (sel_op == OP_MUL);

    // cnt_q is 0 in LAUNCH, so it equals cycles elapsed since the launch.
    assign timeout  = cnt_q >= CNT_WIDTH'(DONE_TIMEOUT - 1);
    assign zero_len = cnt_q == CNT_WIDTH'(WAIT_BUSY_LIMIT);

    assign rsp_valid      = (state_q == StRespond) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign alu_enable_seq = (state_q == StLaunch) && alu_idle;
    assign alu_op_code    = op_q;
    assign alu_operand_1  = opa_q;
    assign alu_operand_2  = opb_q;
    assign rsp_result     = result_q;
    assign rsp_invalid    = invalid_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        invalid_d = invalid_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    owner_d   = lane_sel;
                    op_d      = sel_op;
                    opa_d     = sel_a;
                    opb_d     = sel_b;
                    cnt_d     = '0;
                    result_d  = '0;
                    invalid_d = !legal;
                    state_d   = legal ? StLaunch : StRespond;
                end
            end
            StLaunch: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                cnt_d = cnt_q + 1'b1;
                if (!alu_idle) begin
                    state_d = StWaitDone;
                end else if (zero_len) begin
                    result_d  = alu_result_multi_cycle;
                    invalid_d = 1'b0;
                    state_d   = StRespond;
                end else if (timeout) begin
                    result_d  = '0;
                    invalid_d = 1'b1;
                    state_d   = StRespond;
                end
            end
            StWaitDone: begin
                cnt_d = cnt_q + 1'b1;
                if (alu_idle) begin
                    result_d  = alu_result_multi_cycle;
                    invalid_d = 1'b0;
                    state_d   = StRespond;
                end else if (timeout) begin
                    result_d  = '0;
                    invalid_d = 1'b1;
                    state_d   = StRespond;
                end
            end
            StRespond: begin
                if (rsp_ready[owner_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            invalid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            invalid_q <= invalid_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
